// File: rtl/fp_cvt_pkg.sv
// Shared definitions for the FP format converters: field widths, biases,
// canonical NaNs and the sequencer state encoding.
package fp_cvt_pkg;

  localparam int SP_EXP_W  = 8;
  localparam int SP_FRAC_W = 23;
  localparam int DP_EXP_W  = 11;
  localparam int DP_FRAC_W = 52;

  localparam int EXP_BIAS_SP = 127;
  localparam int EXP_BIAS_DP = 1023;

  localparam logic [DP_EXP_W-1:0] BIAS_DELTA   = 11'd896;
  // Exponent a single subnormal starts from before its first normalising shift.
  localparam logic [DP_EXP_W-1:0] SUB_EXP_INIT = 11'd897;

  localparam logic [63:0] CANON_NAN_DP = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] CANON_NAN_SP = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } cvt_state_t;

endpackage

// File: rtl/fp_sp_classify.sv
// Combinational classifier for a single-precision operand; shared by the
// other single-input FP operations.
module fp_sp_classify
  import fp_cvt_pkg::*;
(
  input  logic [31:0] s,
  output logic        is_zero,
  output logic        is_sub,
  output logic        is_inf,
  output logic        is_nan,
  output logic        is_snan
);

  logic [SP_EXP_W-1:0]  exp_s;
  logic [SP_FRAC_W-1:0] frac_s;
  logic                 exp_zero;
  logic                 exp_ones;
  logic                 frac_zero;

  assign exp_s     = s[30:23];
  assign frac_s    = s[22:0];
  assign exp_zero  = (exp_s == '0);
  assign exp_ones  = (exp_s == '1);
  assign frac_zero = (frac_s == '0);

  assign is_zero = exp_zero & frac_zero;
  assign is_sub  = exp_zero & ~frac_zero;
  assign is_inf  = exp_ones & frac_zero;
  assign is_nan  = exp_ones & ~frac_zero;
  // A NaN is signalling when its quiet bit (frac MSB) is clear.
  assign is_snan = is_nan & ~frac_s[22];

endmodule

// File: rtl/fp_cvt_sd_seq.sv
// Single-to-double conversion with valid/ready handshakes; single subnormals
// are normalised one bit per cycle before the result is presented.
module fp_cvt_sd_seq
  import fp_cvt_pkg::*;
#(
  parameter logic [63:0] CANON_NAN     = 64'h7FF8_0000_0000_0000,
  parameter bit          NAN_KEEP_SIGN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] d,
  output logic        nv
);

  cvt_state_t    state_reg, state_next;
  // Only the 23 fraction bits are kept: the bit that would shift into m[23]
  // is tested as m[22] before the shift, so a 24th bit is never needed.
  logic [22:0]   m_reg, m_next;
  logic [10:0]   e_reg, e_next;
  logic          sign_reg, sign_next;
  logic [63:0]   d_reg, d_next;
  logic          nv_reg, nv_next;

  logic          is_zero, is_sub, is_inf, is_nan, is_snan;
  logic [63:0]   d_direct;
  logic [10:0]   exp_norm;

  fp_sp_classify u_classify (
    .s       (s),
    .is_zero (is_zero),
    .is_sub  (is_sub),
    .is_inf  (is_inf),
    .is_nan  (is_nan),
    .is_snan (is_snan)
  );

  assign exp_norm = {3'b000, s[30:23]} + BIAS_DELTA;

  // Everything except subnormals maps to the double in a single step.
  always_comb begin
    d_direct = {s[31], exp_norm, s[22:0], 29'b0};
    if (is_zero) begin
      d_direct = {s[31], 63'b0};
    end else if (is_inf) begin
      d_direct = {s[31], 11'h7FF, 52'b0};
    end else if (is_nan) begin
      d_direct = NAN_KEEP_SIGN ? {s[31], CANON_NAN[62:0]} : CANON_NAN;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    e_next     = e_reg;
    sign_next  = sign_reg;
    d_next     = d_reg;
    nv_next    = nv_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_NORM: begin
        m_next = m_reg << 1;
        e_next = e_reg - 11'd1;
        if (m_reg[22]) begin
          state_next = ST_DONE;
          d_next     = {sign_reg, e_reg - 11'd1, m_reg[21:0], 30'b0};
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Accept covers both IDLE and the back-to-back slot at the end of DONE.
    if (in_ready && in_valid) begin
      nv_next   = is_snan;
      sign_next = s[31];
      if (is_sub) begin
        m_next     = s[22:0];
        e_next     = SUB_EXP_INIT;
        state_next = ST_NORM;
      end else begin
        d_next     = d_direct;
        state_next = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      m_reg     <= '0;
      e_reg     <= '0;
      sign_reg  <= 1'b0;
      d_reg     <= '0;
      nv_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      e_reg     <= e_next;
      sign_reg  <= sign_next;
      d_reg     <= d_next;
      nv_reg    <= nv_next;
    end
  end

  assign d  = d_reg;
  assign nv = nv_reg;

endmodule

// File: tb/tb_fp_cvt_sd_seq.sv
// Directed bench for fp_cvt_sd_seq: value mapping, NORM-cycle counts,
// backpressure with back-to-back accept, and reset during normalisation.
module tb_fp_cvt_sd_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] d;
  logic        nv;

  int n_assert;
  int n_fail;

  fp_cvt_sd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .nv        (nv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one operand, count cycles spent before out_valid (NORM cycles,
  // with in_ready required low in each), then check and drain the result.
  task automatic run_vec(input string tag, input logic [31:0] sv, input logic [63:0] exp_d,
                         input logic exp_nv, input int exp_norm);
    int lat;
    @(negedge clk);
    s        = sv;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    s        = 32'hDEAD_BEEF;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      check({tag, "_norm_in_ready"}, {63'b0, in_ready}, 64'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_norm_cycles"}, 64'(lat), 64'(exp_norm));
    check({tag, "_d"}, d, exp_d);
    check({tag, "_nv"}, {63'b0, nv}, {63'b0, exp_nv});
    $display("vec %s s=%h d=%h nv=%0b norm_cycles=%0d", tag, sv, d, nv, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drained"}, {63'b0, out_valid}, 64'd0);
  endtask

  initial begin
    int quiet_ok;
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    s         = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_d", d, 64'd0);
    check("rst_nv", {63'b0, nv}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {63'b0, in_ready}, 64'd1);

    run_vec("one",      32'h3F80_0000, 64'h3FF0_0000_0000_0000, 1'b0, 0);
    run_vec("neg_zero", 32'h8000_0000, 64'h8000_0000_0000_0000, 1'b0, 0);
    run_vec("neg_inf",  32'hFF80_0000, 64'hFFF0_0000_0000_0000, 1'b0, 0);
    run_vec("snan",     32'h7FA0_0000, 64'h7FF8_0000_0000_0000, 1'b1, 0);
    run_vec("qnan",     32'h7FC0_0000, 64'h7FF8_0000_0000_0000, 1'b0, 0);
    run_vec("neg_qnan", 32'hFFC0_0000, 64'h7FF8_0000_0000_0000, 1'b0, 0);
    run_vec("max_norm", 32'h7F7F_FFFF, 64'h47EF_FFFF_E000_0000, 1'b0, 0);
    run_vec("min_norm", 32'h0080_0000, 64'h3810_0000_0000_0000, 1'b0, 0);
    run_vec("sub_top",  32'h0040_0000, 64'h3800_0000_0000_0000, 1'b0, 1);
    run_vec("sub_min",  32'h0000_0001, 64'h36A0_0000_0000_0000, 1'b0, 23);
    run_vec("sub_neg3", 32'h8000_0003, 64'hB6B8_0000_0000_0000, 1'b0, 22);

    // Backpressure: hold the result, then accept a new operand on the release cycle.
    @(negedge clk);
    s        = 32'h3F80_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      check("bp_d_stable", d, 64'h3FF0_0000_0000_0000);
      check("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    s         = 32'h4000_0000;
    in_valid  = 1'b1;
    #1;
    check("b2b_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_out_valid", {63'b0, out_valid}, 64'd1);
    check("b2b_d", d, 64'h4000_0000_0000_0000);
    $display("vec b2b s=40000000 d=%h out_valid=%0b", d, out_valid);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of a long normalisation.
    s        = 32'h0000_0001;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_norm_in_ready", {63'b0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", {63'b0, out_valid}, 64'd0);
    check("abort_d", d, 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    quiet_ok  = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) quiet_ok = 0;
    end
    out_ready = 1'b0;
    check("abort_no_output", 64'(quiet_ok), 64'd1);
    $display("vec abort out_valid_seen=%0d", 1 - quiet_ok);

    run_vec("after_rst", 32'h3F80_0000, 64'h3FF0_0000_0000_0000, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
